adc_multi_sampler: RTL and testbench
====================================

// Module: adc_multi_sampler
// PURPOSE
// Multi-channel successor to the single-channel serial ADC reader. Drives one shared
// cs/sclk pair to N_CH serial ADCs (AD7476-class, one sdo line each) and captures all
// channels in parallel. Adds single-shot/continuous modes, 2^AVG_LOG2 frame averaging
// and a recalibration request queue. Sits between the sampling scheduler and control loop.
// PARAMETERS
// N_CH        3   number of ADCs/sdo lines sharing cs and sclk
// DATA_W      12  conversion result width
// LEAD_BITS   4   leading bits per frame, discarded (sclk falling edges 0..LEAD_BITS-1)
// TRAIL_BITS  0   trailing bits per frame, discarded
// CLK_DIV     10  clk cycles per sclk half-period (>=1); sclk = clk/(2*CLK_DIV)
// CAL_CLKS    32  sclk periods with cs low for a calibration frame (data ignored)
// QUIET_CLKS  1   sclk periods cs is held high after each frame (tQUIET)
// AVG_LOG2    0   frames averaged per result = 2^AVG_LOG2 (0 = no averaging)
// PORTS
// clk          in   1            system clock; sole clock domain, sclk is a generated output
// reset        in   1            asynchronous, active-low
// start        in   1            single-shot request, sampled only in IDLE
// continuous   in   1            1 = auto-start a new burst whenever IDLE
// recalibrate  in   1            request a calibration frame
// sdo          in   N_CH         serial data, bit i from ADC i
// cs           out  1            shared chip select, active low
// sclk         out  1            shared serial clock, idles high
// data         out  N_CH*DATA_W  results; channel i at [i*DATA_W +: DATA_W]
// data_valid   out  1            one-cycle pulse, data updated this cycle
// busy         out  1            1 whenever state != IDLE
// cal_done     out  1            1 after the first calibration completes; 0 only after reset
// BEHAVIOUR
// - Reset (async assert, sync release): cs=1, sclk=1, data=0, data_valid=0, busy=1,
//   cal_done=0, accumulators/counters/pending flags=0, state=CAL.
// - FRAME_BITS = LEAD_BITS+DATA_W+TRAIL_BITS. sclk toggles every CLK_DIV clk while cs=0,
//   starting high; one sclk period = 2*CLK_DIV clk. All sdo sampled in the clk cycle sclk
//   is driven 1->0; falling edges k in [LEAD_BITS, LEAD_BITS+DATA_W) shift in MSB first.
// - States: CAL -> QUIET -> IDLE; IDLE -> CAL | CONV; CONV -> QUIET -> (CONV | IDLE | CAL).
//   CAL: cs=0 for CAL_CLKS sclk periods, no data out; on exit cal_done=1.
//   CONV: cs=0 for FRAME_BITS sclk periods; cs rises the cycle after the last period ends.
//   QUIET: cs=1, sclk=1 for QUIET_CLKS sclk periods; then next burst frame, else pending
//   recalibrate -> CAL, else continuous -> CONV (new burst), else IDLE.
// - IDLE priority: recalibrate > (start | continuous). start with recalibrate is dropped.
// - Burst = 2^AVG_LOG2 consecutive frames. Per-channel accumulator DATA_W+AVG_LOG2 bits,
//   no overflow possible; result = acc >> AVG_LOG2 (truncate). Accumulators clear at burst start.
// - data/data_valid update 1 clk after cs rises on the last frame of a burst; data holds
//   until next update. AVG_LOG2=0 latency start->data_valid = 2 + 2*CLK_DIV*FRAME_BITS clk.
// - start while busy: ignored (no queueing). recalibrate while busy: latched as pending,
//   serviced at the next QUIET exit (after current burst ends); repeated requests merge.
// - continuous deasserted mid-burst: current burst completes and reports, then IDLE.
// - reset mid-frame: cs rises immediately (async); partial data discarded; calibrates again.
// TESTING
// 1 Reset release, CLK_DIV=2: cs low exactly 32*4=128 clk, cal_done=1, busy=0 after QUIET.
// 2 start, sdo[i] drives 0000+12'hA5C / 12'h3FF / 12'h001 -> data_valid at start+66 clk,
//   channels = 12'hA5C, 12'h3FF, 12'h001; exactly 16 sclk falls while cs=0.
// 3 AVG_LOG2=2, frames 100,101,102,104 on ch0 -> single data_valid, ch0 = 101 (407>>2).
// 4 continuous=1 for 3 results then 0 -> exactly 3 pulses spaced (16+1)*4 clk apart, then IDLE.
// 5 recalibrate mid-CONV -> frame completes and reports, then 128-clk CAL, no extra data_valid.
// 6 reset asserted at bit 7 -> cs=1, sclk=1, data_valid=0 same cycle; restarts with CAL.

Source files
------------

// File: rtl/adc_multi_sampler_if.sv
// Shared serial ADC bus: one chip select and serial clock fanned out to N_CH
// converters, one sdo line back from each converter.
interface adc_multi_sampler_if #(
    parameter int N_CH = 3
);
    logic            cs;
    logic            sclk;
    logic [N_CH-1:0] sdo;

    modport master (output cs, output sclk, input sdo);
    modport slave  (input cs, input sclk, output sdo);
endinterface

// File: rtl/adc_multi_sampler.sv
// Multi-channel serial ADC sampler: one cs/sclk pair, N_CH sdo lines captured in
// parallel, burst averaging and queued recalibration.

module adc_ms_lane #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdo_bit,
    input  logic              shift_en,
    input  logic              acc_clr,
    input  logic              acc_add,
    input  logic              load,
    output logic [DATA_W-1:0] result
);
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0] sh_q, sh_d, res_q, res_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        sh_d  = shift_en ? {sh_q[DATA_W-2:0], sdo_bit} : sh_q;
        acc_d = acc_q;
        if (acc_clr)
            acc_d = '0;
        else if (acc_add)
            acc_d = acc_q + ACC_W'(sh_q);
        res_d = load ? acc_q[ACC_W-1:AVG_LOG2] : res_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            sh_q  <= sh_d;
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;
endmodule

module adc_multi_sampler #(
    parameter int N_CH       = 3,
    parameter int DATA_W     = 12,
    parameter int LEAD_BITS  = 4,
    parameter int TRAIL_BITS = 0,
    parameter int CLK_DIV    = 10,
    parameter int CAL_CLKS   = 32,
    parameter int QUIET_CLKS = 1,
    parameter int AVG_LOG2   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     recalibrate,
    adc_multi_sampler_if.master      bus,
    output logic [N_CH*DATA_W-1:0]   data,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     cal_done
);
    localparam int FRAME_BITS = LEAD_BITS + DATA_W + TRAIL_BITS;
    localparam int MAXP0      = (CAL_CLKS > FRAME_BITS) ? CAL_CLKS : FRAME_BITS;
    localparam int MAXP       = (MAXP0 > QUIET_CLKS) ? MAXP0 : QUIET_CLKS;
    localparam int HALF_W     = $clog2(2 * MAXP);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int FRM_W      = AVG_LOG2 + 1;

    localparam logic [HALF_W-1:0] CAL_LAST   = HALF_W'(2 * CAL_CLKS - 1);
    localparam logic [HALF_W-1:0] CONV_LAST  = HALF_W'(2 * FRAME_BITS - 1);
    localparam logic [HALF_W-1:0] QUIET_LAST = HALF_W'(2 * QUIET_CLKS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    // frm_q == NFRM marks "no burst in progress"
    localparam logic [FRM_W-1:0]  NFRM       = FRM_W'(2 ** AVG_LOG2);

    localparam logic [1:0] S_CAL   = 2'd0;
    localparam logic [1:0] S_QUIET = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_CONV  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              cs_q, cs_d, sclk_q, sclk_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              pend_q, pend_d, cal_done_q, cal_done_d;
    logic              rpt_q, rpt_d, dv_q, dv_d;

    logic              div_end, in_data;
    logic [HALF_W-1:0] bit_idx;
    logic              shift_en, acc_clr, acc_add, out_load;
    logic [N_CH-1:0][DATA_W-1:0] res;

    assign div_end = (div_q == DIV_LAST);
    assign bit_idx = half_q >> 1;
    assign in_data = (int'(bit_idx) >= LEAD_BITS) && (int'(bit_idx) < LEAD_BITS + DATA_W);

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        div_d      = div_q;
        half_d     = half_q;
        frm_d      = frm_q;
        pend_d     = pend_q;
        cal_done_d = cal_done_q;
        rpt_d      = 1'b0;
        dv_d       = rpt_q;
        out_load   = rpt_q;
        shift_en   = 1'b0;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        if (recalibrate && state_q != S_IDLE)
            pend_d = 1'b1;
        case (state_q)
            S_CAL, S_CONV: begin
                if (cs_q) begin
                    // only reachable straight out of reset
                    cs_d   = 1'b0;
                    sclk_d = 1'b1;
                    div_d  = '0;
                    half_d = '0;
                end else begin
                    div_d = div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        sclk_d = ~sclk_q;
                        half_d = half_q + 1'b1;
                        if (state_q == S_CONV && sclk_q && in_data)
                            shift_en = 1'b1;
                        if (half_q == ((state_q == S_CAL) ? CAL_LAST : CONV_LAST)) begin
                            cs_d    = 1'b1;
                            sclk_d  = 1'b1;
                            half_d  = '0;
                            state_d = S_QUIET;
                            if (state_q == S_CAL) begin
                                cal_done_d = 1'b1;
                            end else begin
                                acc_add = 1'b1;
                                frm_d   = frm_q + 1'b1;
                                rpt_d   = (frm_q == NFRM - 1'b1);
                            end
                        end
                    end
                end
            end
            S_QUIET: begin
                div_d = div_end ? '0 : div_q + 1'b1;
                if (div_end) begin
                    half_d = half_q + 1'b1;
                    if (half_q == QUIET_LAST) begin
                        half_d = '0;
                        if (frm_q != NFRM) begin
                            state_d = S_CONV;
                            cs_d    = 1'b0;
                        end else if (pend_q || recalibrate) begin
                            state_d = S_CAL;
                            cs_d    = 1'b0;
                            pend_d  = 1'b0;
                        end else if (continuous) begin
                            state_d = S_CONV;
                            cs_d    = 1'b0;
                            frm_d   = '0;
                            acc_clr = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                if (recalibrate) begin
                    state_d = S_CAL;
                    cs_d    = 1'b0;
                end else if (start || continuous) begin
                    state_d = S_CONV;
                    cs_d    = 1'b0;
                    frm_d   = '0;
                    acc_clr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CAL;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            div_q      <= '0;
            half_q     <= '0;
            frm_q      <= NFRM;
            pend_q     <= 1'b0;
            cal_done_q <= 1'b0;
            rpt_q      <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            div_q      <= div_d;
            half_q     <= half_d;
            frm_q      <= frm_d;
            pend_q     <= pend_d;
            cal_done_q <= cal_done_d;
            rpt_q      <= rpt_d;
            dv_q       <= dv_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        adc_ms_lane #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .sdo_bit  (bus.sdo[i]),
            .shift_en (shift_en),
            .acc_clr  (acc_clr),
            .acc_add  (acc_add),
            .load     (out_load),
            .result   (res[i])
        );
    end

    assign bus.cs     = cs_q;
    assign bus.sclk   = sclk_q;
    assign data       = res;
    assign data_valid = dv_q;
    assign busy       = (state_q != S_IDLE);
    assign cal_done   = cal_done_q;
endmodule

// File: tb/tb_adc_multi_sampler.sv
// Bench for adc_multi_sampler: ADC serial models, vector table, random frames
// and hand-written sequences for continuous, recalibrate and mid-frame reset.
module tb_adc_multi_sampler;
    localparam int N_CH    = 3;
    localparam int DW      = 12;
    localparam int CLK_DIV = 2;
    localparam int FB      = 16;
    localparam int CALP    = 32;
    localparam int QUIETP  = 1;
    localparam int LAT     = 2 + 2 * CLK_DIV * FB;
    localparam int CAL_LOW = 2 * CLK_DIV * CALP;
    localparam int QCYC    = 2 * CLK_DIV * QUIETP;
    localparam int PERIOD  = (FB + QUIETP) * 2 * CLK_DIV;

    typedef logic [N_CH-1:0][DW-1:0] words_t;
    typedef struct {
        words_t              w;
        logic [N_CH*DW-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start0, cont0, recal0, start2;
    logic [N_CH*DW-1:0] data0, data2;
    logic dv0, busy0, cd0, dv2, busy2, cd2;
    words_t w0, w2;
    int fc0 = 0, fc2 = 0, dvcnt0 = 0, dvcnt2 = 0;
    int total = 0, bad = 0;

    adc_multi_sampler_if #(.N_CH(N_CH)) bus0 ();
    adc_multi_sampler_if #(.N_CH(N_CH)) bus2 ();

    adc_multi_sampler #(.N_CH(N_CH), .DATA_W(DW), .CLK_DIV(CLK_DIV), .AVG_LOG2(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .continuous(cont0), .recalibrate(recal0),
        .bus(bus0), .data(data0), .data_valid(dv0), .busy(busy0), .cal_done(cd0));
    adc_multi_sampler #(.N_CH(N_CH), .DATA_W(DW), .CLK_DIV(CLK_DIV), .AVG_LOG2(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .recalibrate(1'b0),
        .bus(bus2), .data(data2), .data_valid(dv2), .busy(busy2), .cal_done(cd2));

    always #5 clk = ~clk;

    // ADC model: bit index = sclk falls since cs fell, frame = 0000 + word
    always @(negedge bus0.sclk or posedge bus0.cs) if (bus0.cs) fc0 <= 0; else fc0 <= fc0 + 1;
    always @(negedge bus2.sclk or posedge bus2.cs) if (bus2.cs) fc2 <= 0; else fc2 <= fc2 + 1;

    function automatic logic [N_CH-1:0] sdo_of(input words_t w, input int fc);
        logic [FB-1:0] fr;
        sdo_of = '0;
        for (int i = 0; i < N_CH; i++) begin
            fr = {4'b0000, w[i]};
            if (fc >= 0 && fc < FB) sdo_of[i] = fr[FB-1-fc];
        end
    endfunction

    assign bus0.sdo = sdo_of(w0, fc0);
    assign bus2.sdo = sdo_of(w2, fc2);

    always @(posedge clk) begin
        if (dv0) dvcnt0 <= dvcnt0 + 1;
        if (dv2) dvcnt2 <= dvcnt2 + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic words_t rnd_w();
        for (int i = 0; i < N_CH; i++) rnd_w[i] = DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    function automatic logic [N_CH*DW-1:0] flat(input words_t w);
        flat = '0;
        for (int i = 0; i < N_CH; i++) flat[i*DW +: DW] = w[i];
    endfunction

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy0 && !busy2) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) tmo(nm);
    endtask

    // counts cs-low cycles of u0 until it goes idle after a reset release or recal
    task automatic measure_cal(input string nm, input int exp_n);
        int low, n, dvx;
        bit ok;
        low = 0; n = 0; dvx = 0; ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            n++;
            if (!bus0.cs) low++;
            if (dv0) dvx++;
            if (!busy0) begin ok = 1'b1; break; end
        end
        if (!ok) tmo({nm, "_idle"});
        else begin
            chk({nm, "_cs_low"}, 64'(low), 64'(CAL_LOW));
            if (exp_n > 0) chk({nm, "_cycles"}, 64'(n), 64'(exp_n));
            chk({nm, "_no_dv"}, 64'(dvx), 64'd0);
            chk({nm, "_cal_done"}, 64'(cd0), 64'd1);
        end
    endtask

    task automatic run_vec(input words_t w, input logic [N_CH*DW-1:0] exp, input string nm);
        int maxfc;
        bit got;
        int lat;
        w0 = w;
        @(negedge clk);
        start0 = 1'b1;
        got = 1'b0; maxfc = 0; lat = 0;
        for (int l = 1; l <= LAT + 20; l++) begin
            tick();
            lat = l;
            if (l == 1) start0 = 1'b0;
            if (!bus0.cs && fc0 > maxfc) maxfc = fc0;
            if (dv0) begin got = 1'b1; break; end
        end
        if (!got) tmo({nm, "_dv"});
        else begin
            chk({nm, "_lat"}, 64'(lat), 64'(LAT));
            chk({nm, "_data"}, 64'(data0), 64'(exp));
            chk({nm, "_falls"}, 64'(maxfc), 64'(FB));
        end
        wait_idle({nm, "_idle"});
    endtask

    task automatic wait_cs2(input logic lvl, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus2.cs == lvl) begin ok = 1'b1; break; end
        end
        if (!ok) tmo(nm);
    endtask

    task automatic run_avg(input words_t fr0, input words_t fr1, input words_t fr2,
                           input words_t fr3, input string nm);
        words_t fr[4];
        int sum;
        logic [N_CH*DW-1:0] exp;
        int d_before;
        bit got;
        fr[0] = fr0; fr[1] = fr1; fr[2] = fr2; fr[3] = fr3;
        for (int c = 0; c < N_CH; c++) begin
            sum = 0;
            for (int f = 0; f < 4; f++) sum += int'(fr[f][c]);
            exp[c*DW +: DW] = DW'(sum / 4);
        end
        d_before = dvcnt2;
        w2 = fr[0];
        @(negedge clk);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int f = 1; f < 4; f++) begin
            wait_cs2(1'b1, {nm, "_cs_rise"});
            w2 = fr[f];
            wait_cs2(1'b0, {nm, "_cs_fall"});
        end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dv2) begin got = 1'b1; break; end
        end
        if (!got) tmo({nm, "_dv"});
        else chk({nm, "_data"}, 64'(data2), 64'(exp));
        wait_idle({nm, "_idle"});
        repeat (20) tick();
        chk({nm, "_pulses"}, 64'(dvcnt2 - d_before), 64'd1);
    endtask

    initial begin
        vec_t vt[4];
        words_t t, fa, fb, fc, fd, exp_w;
        int d0, prev, pulses, lat, dvx;
        bit got;

        vt[0].w = {12'h001, 12'h3FF, 12'hA5C}; vt[0].exp = 36'h001_3FF_A5C;
        vt[1].w = {12'hFFF, 12'hFFF, 12'hFFF}; vt[1].exp = 36'hFFF_FFF_FFF;
        vt[2].w = {12'h000, 12'h000, 12'h000}; vt[2].exp = 36'h000_000_000;
        vt[3].w = {12'h800, 12'h555, 12'hAAA}; vt[3].exp = 36'h800_555_AAA;

        reset = 1'b0; start0 = 1'b0; cont0 = 1'b0; recal0 = 1'b0; start2 = 1'b0;
        w0 = '0; w2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 64'(bus0.cs), 64'd1);
        chk("rst_sclk", 64'(bus0.sclk), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd1);
        chk("rst_cal_done", 64'(cd0), 64'd0);
        chk("rst_dv", 64'(dv0), 64'd0);
        chk("rst_data", 64'(data0), 64'd0);

        @(negedge clk);
        reset = 1'b1;
        measure_cal("boot_cal", CAL_LOW + QCYC + 1);
        wait_idle("boot_idle2");
        chk("boot_cal_done2", 64'(cd2), 64'd1);

        for (int v = 0; v < 4; v++) run_vec(vt[v].w, vt[v].exp, $sformatf("vec%0d", v));
        for (int v = 0; v < 6; v++) begin
            t = rnd_w();
            run_vec(t, flat(t), $sformatf("rnd%0d", v));
        end

        fa = rnd_w(); fb = rnd_w(); fc = rnd_w(); fd = rnd_w();
        fa[0] = 12'd100; fb[0] = 12'd101; fc[0] = 12'd102; fd[0] = 12'd104;
        fa[1] = 12'hFFF; fb[1] = 12'hFFF; fc[1] = 12'hFFF; fd[1] = 12'hFFF;
        run_avg(fa, fb, fc, fd, "avg_fixed");
        run_avg(rnd_w(), rnd_w(), rnd_w(), rnd_w(), "avg_rnd");

        // continuous: three results, fresh words after each, then drop continuous
        d0 = dvcnt0; prev = -1; pulses = 0;
        w0 = rnd_w(); exp_w = w0;
        @(negedge clk);
        cont0 = 1'b1;
        for (int n = 1; n < 400; n++) begin
            tick();
            if (dv0) begin
                pulses++;
                chk($sformatf("cont_data%0d", pulses), 64'(data0), 64'(flat(exp_w)));
                if (prev >= 0) chk($sformatf("cont_gap%0d", pulses), 64'(n - prev), 64'(PERIOD));
                prev = n;
                w0 = rnd_w(); exp_w = w0;
                if (pulses == 3) begin cont0 = 1'b0; break; end
            end
        end
        if (pulses != 3) begin cont0 = 1'b0; tmo("cont_pulses"); end
        wait_idle("cont_idle");
        repeat (150) tick();
        chk("cont_total", 64'(dvcnt0 - d0), 64'd3);
        chk("cont_busy", 64'(busy0), 64'd0);

        // recalibrate mid-frame: frame reports, then a full calibration, no extra data
        t = rnd_w(); w0 = t; got = 1'b0; lat = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int l = 1; l <= LAT + 20; l++) begin
            tick();
            lat = l;
            if (l == 1) start0 = 1'b0;
            recal0 = (l == 30);
            if (dv0) begin got = 1'b1; break; end
        end
        recal0 = 1'b0;
        if (!got) tmo("recal_dv");
        else begin
            chk("recal_lat", 64'(lat), 64'(LAT));
            chk("recal_data", 64'(data0), 64'(flat(t)));
        end
        measure_cal("recal_cal", 0);

        // reset at bit 7 of a frame
        w0 = rnd_w(); got = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        for (int l = 1; l < 200; l++) begin
            tick();
            start0 = 1'b0;
            if (fc0 == 7) begin got = 1'b1; break; end
        end
        if (!got) tmo("mid_bit7");
        reset = 1'b0;
        #1;
        chk("mid_cs", 64'(bus0.cs), 64'd1);
        chk("mid_sclk", 64'(bus0.sclk), 64'd1);
        chk("mid_dv", 64'(dv0), 64'd0);
        chk("mid_busy", 64'(busy0), 64'd1);
        chk("mid_data", 64'(data0), 64'd0);
        chk("mid_cal_done", 64'(cd0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        measure_cal("mid_cal", CAL_LOW + QCYC + 1);
        wait_idle("mid_idle");
        dvx = dvcnt0;
        t = rnd_w();
        run_vec(t, flat(t), "post_rst");
        chk("post_rst_pulses", 64'(dvcnt0 - dvx), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
